// File: rtl/mult_pipe_param.sv
// mult_pipe_param: pipelined WIDTH x WIDTH signed/unsigned multiplier; magnitudes feed a
// registered binary adder tree and the sign is applied in the output stage.
module mult_pipe_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               tc,
  input  logic               s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   C,
  output logic [2*WIDTH-1:0] P
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int N = 2*WIDTH;
  logic             w_en;
  logic [WIDTH-1:0] w_ma, w_mb;
  logic [N-1:0]     w_sum;
  // Heap-ordered tree: leaves at WIDTH-1..2*WIDTH-2, node i sums nodes 2i+1 and 2i+2
  logic [N-1:0]     r_t [2*WIDTH-1];
  logic [LEVELS:0]  r_v, r_neg, r_s;
  assign w_en = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_ma = (tc && A[WIDTH-1]) ? -A : A;
  assign w_mb = (tc && B[WIDTH-1]) ? -B : B;
  assign w_sum = r_neg[LEVELS] ? -r_t[0] : r_t[0];
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 2*WIDTH-1; i++) r_t[i] <= '0;
      r_v <= '0;
      r_neg <= '0;
      r_s <= '0;
      out_valid <= 1'b0;
      C <= '0;
      P <= '0;
    end else if (w_en) begin
      for (int j = 0; j < WIDTH; j++) r_t[WIDTH-1+j] <= w_ma[j] ? {{WIDTH{1'b0}}, w_mb} << j : '0;
      for (int i = 0; i < WIDTH-1; i++) r_t[i] <= r_t[2*i+1] + r_t[2*i+2];
      r_v <= {r_v[LEVELS-1:0], in_valid};
      r_neg <= {r_neg[LEVELS-1:0], tc && (A[WIDTH-1] ^ B[WIDTH-1])};
      r_s <= {r_s[LEVELS-1:0], s};
      out_valid <= r_v[LEVELS];
      P <= w_sum;
      C <= r_s[LEVELS] ? w_sum[WIDTH-1:0] : w_sum[N-1:WIDTH];
    end
endmodule
